// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline register: branch and ALU
// encodings plus the packed flag layout.
package ex_mem_stage_pkg;

  localparam int unsigned WIDTH_DEF    = 32;
  localparam int unsigned REG_BITS_DEF = 5;

  // Branch condition selected by the decoder
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_LT   = 2'b11
  } br_e;

  // ALU operation codes of the upstream ALU
  typedef enum logic [1:0] {
    ALU_NOR = 2'b00,
    ALU_SLT = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_e;

  // Sticky condition codes, ordered {N,Z,V,C} to match the flags_q port
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/ex_mem_stage_branch_eval.sv
// Combinational branch resolution from the ALU flags of the current EX op.
// LT is the signed comparison taken from a SUB result: N xor V.
module ex_mem_stage_branch_eval
  import ex_mem_stage_pkg::*;
(
  input  br_e  i_branch,
  input  logic i_z,
  input  logic i_n,
  input  logic i_v,
  output logic o_taken
);

  // Select the condition implied by the branch type
  always_comb begin
    // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
    o_taken = 1'b0;
    case (i_branch)
      BR_EQ:   o_taken = i_z;
      BR_NE:   o_taken = ~i_z;
      BR_LT:   o_taken = i_n ^ i_v;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Captures the ALU result and EX control, resolves
// the branch, keeps sticky NZVC flags and an overflow-trap latch, and drives
// forwarding plus a single-cycle PC redirect.
// Edge priority: reset > flush > stall > load.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned REG_BITS = REG_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [WIDTH-1:0]    alu_out,
  input  logic                alu_carry,
  input  logic                alu_zero,
  input  logic                alu_ovf,
  input  logic                alu_neg,
  input  logic [WIDTH-1:0]    ex_storedata,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_regwrite,
  input  logic                ex_memread,
  input  logic                ex_memwrite,
  input  logic                ex_setflags,
  input  logic                ex_trap_ovf,
  input  logic [1:0]          ex_branch,
  input  logic [WIDTH-1:0]    ex_target,
  input  logic                trap_ack,
  output logic                mem_valid,
  output logic [WIDTH-1:0]    mem_aluresult,
  output logic [WIDTH-1:0]    mem_storedata,
  output logic [REG_BITS-1:0] mem_rd,
  output logic                mem_regwrite,
  output logic                mem_memread,
  output logic                mem_memwrite,
  output logic [REG_BITS-1:0] fwd_rd,
  output logic [WIDTH-1:0]    fwd_data,
  output logic [3:0]          flags_q,
  output logic                redirect,
  output logic [WIDTH-1:0]    redirect_pc,
  output logic                ovf_trap
);

  logic                r_valid;
  logic                r_regwrite;
  logic                r_memread;
  logic                r_memwrite;
  logic                r_br_taken;
  logic                r_redirect_done;
  logic [WIDTH-1:0]    r_aluresult;
  logic [WIDTH-1:0]    r_storedata;
  logic [REG_BITS-1:0] r_rd;
  logic [WIDTH-1:0]    r_target;
  flags_t              r_flags;
  logic                r_ovf_trap;

  logic w_load;
  logic w_trap;
  logic w_set_flags;
  logic w_taken;

  // A load happens only when neither flush nor stall is asserted
  assign w_load      = ~flush & ~stall;
  assign w_trap      = ex_valid & ex_trap_ovf & alu_ovf;
  assign w_set_flags = ex_valid & ex_setflags & ~w_trap;

  ex_mem_stage_branch_eval u_branch_eval (
    .i_branch (br_e'(ex_branch)),
    .i_z      (alu_zero),
    .i_n      (alu_neg),
    .i_v      (alu_ovf),
    .o_taken  (w_taken)
  );

  // Valid bit and control: flush inserts a bubble, stall holds, load captures
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_br_taken <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_br_taken <= 1'b0;
    end else if (!stall) begin
      r_valid    <= ex_valid;
      r_regwrite <= ex_regwrite & ~w_trap;
      r_memread  <= ex_memread;
      r_memwrite <= ex_memwrite & ~w_trap;
      r_br_taken <= w_taken;
    end
  end

  // Datapath capture; contents are irrelevant after a flush, so it simply holds
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aluresult <= '0;
      r_storedata <= '0;
      r_rd        <= '0;
      r_target    <= '0;
    end else if (w_load) begin
      r_aluresult <= alu_out;
      r_storedata <= ex_storedata;
      r_rd        <= ex_rd;
      r_target    <= ex_target;
    end
  end

  // Sticky flags and overflow trap update only on a load; a new trap beats trap_ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags    <= '0;
      r_ovf_trap <= 1'b0;
    end else if (w_load) begin
      if (w_set_flags) begin
        r_flags <= '{n: alu_neg, z: alu_zero, v: alu_ovf, c: alu_carry};
      end
      if (w_trap) begin
        r_ovf_trap <= 1'b1;
      end else if (trap_ack) begin
        r_ovf_trap <= 1'b0;
      end
    end
  end

  // Remember that the redirect already fired so a stalled branch pulses once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_done <= 1'b0;
    end else if (flush || !stall) begin
      r_redirect_done <= 1'b0;
    end else if (redirect) begin
      r_redirect_done <= 1'b1;
    end
  end

  assign mem_valid     = r_valid;
  assign mem_aluresult = r_aluresult;
  assign mem_storedata = r_storedata;
  assign mem_rd        = r_rd;
  assign mem_regwrite  = r_regwrite;
  assign mem_memread   = r_memread;
  assign mem_memwrite  = r_memwrite;
  assign fwd_rd        = (r_valid & r_regwrite & (r_rd != '0)) ? r_rd : '0;
  assign fwd_data      = r_aluresult;
  assign flags_q       = r_flags;
  assign redirect      = r_valid & r_br_taken & ~r_redirect_done;
  assign redirect_pc   = r_target;
  assign ovf_trap      = r_ovf_trap;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a behavioural model predicts the state after each
// edge, the prediction is queued when inputs are applied and popped/compared
// one time unit after the edge. Directed cases add fixed expected constants.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, ex_valid;
  logic [31:0] alu_out, ex_storedata, ex_target;
  logic        alu_carry, alu_zero, alu_ovf, alu_neg;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_setflags, ex_trap_ovf;
  logic [1:0]  ex_branch;
  logic        trap_ack;

  logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite;
  logic [31:0] mem_aluresult, mem_storedata, fwd_data, redirect_pc;
  logic [4:0]  mem_rd, fwd_rd;
  logic [3:0]  flags_q;
  logic        redirect, ovf_trap;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .alu_neg(alu_neg), .ex_storedata(ex_storedata), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_setflags(ex_setflags), .ex_trap_ovf(ex_trap_ovf), .ex_branch(ex_branch),
    .ex_target(ex_target), .trap_ack(trap_ack),
    .mem_valid(mem_valid), .mem_aluresult(mem_aluresult), .mem_storedata(mem_storedata),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flags_q(flags_q), .redirect(redirect), .redirect_pc(redirect_pc), .ovf_trap(ovf_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rw, mr, mw, redirect, trap, dp;
    logic [31:0] res, sd, rpc;
    logic [4:0]  rd, fwd_rd;
    logic [3:0]  flags;
  } exp_t;

  exp_t exp_q[$];

  // Model state
  logic        m_valid, m_rw, m_mr, m_mw, m_taken, m_done, m_trap, m_dp;
  logic [31:0] m_res, m_sd, m_tgt;
  logic [4:0]  m_rd;
  logic [3:0]  m_flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; ex_valid = 0;
    alu_out = '0; ex_storedata = '0; ex_target = '0;
    alu_carry = 0; alu_zero = 0; alu_ovf = 0; alu_neg = 0;
    ex_rd = '0; ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0;
    ex_setflags = 0; ex_trap_ovf = 0; ex_branch = 2'b00; trap_ack = 0;
  endtask

  // Predict the effect of the coming edge given the currently applied inputs
  task automatic model_edge();
    logic redir_now, trap, taken;
    redir_now = m_valid & m_taken & ~m_done;
    trap      = ex_valid & ex_trap_ovf & alu_ovf;
    case (ex_branch)
      2'b00:   taken = 1'b0;
      2'b01:   taken = alu_zero;
      2'b10:   taken = ~alu_zero;
      default: taken = alu_neg ^ alu_ovf;
    endcase
    if (reset) begin
      {m_valid, m_rw, m_mr, m_mw, m_taken, m_done, m_trap} = '0;
      m_res = '0; m_sd = '0; m_tgt = '0; m_rd = '0; m_flags = '0; m_dp = 1'b1;
    end else if (flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_taken, m_done} = '0;
      m_dp = 1'b0;
    end else if (stall) begin
      if (redir_now) m_done = 1'b1;
    end else begin
      m_valid = ex_valid;
      m_rw    = ex_regwrite && !trap;
      m_mr    = ex_memread;
      m_mw    = ex_memwrite && !trap;
      m_taken = taken;
      m_done  = 1'b0;
      m_res   = alu_out; m_sd = ex_storedata; m_rd = ex_rd; m_tgt = ex_target;
      m_dp    = 1'b1;
      if (ex_valid && ex_setflags && !trap) m_flags = {alu_neg, alu_zero, alu_ovf, alu_carry};
      if (trap) m_trap = 1'b1;
      else if (trap_ack) m_trap = 1'b0;
    end
  endtask

  // Apply current inputs for one edge, then compare DUT against the queued prediction
  task automatic step();
    exp_t e;
    model_edge();
    e.valid = m_valid; e.rw = m_rw; e.mr = m_mr; e.mw = m_mw;
    e.redirect = m_valid & m_taken & ~m_done;
    e.trap = m_trap; e.dp = m_dp;
    e.res = m_res; e.sd = m_sd; e.rpc = m_tgt; e.rd = m_rd;
    e.fwd_rd = (m_valid && m_rw && m_rd != 5'd0) ? m_rd : 5'd0;
    e.flags = m_flags;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("mem_valid", 32'(mem_valid), 32'(e.valid));
    check("mem_regwrite", 32'(mem_regwrite), 32'(e.rw));
    check("mem_memread", 32'(mem_memread), 32'(e.mr));
    check("mem_memwrite", 32'(mem_memwrite), 32'(e.mw));
    check("fwd_rd", 32'(fwd_rd), 32'(e.fwd_rd));
    check("flags_q", 32'(flags_q), 32'(e.flags));
    check("redirect", 32'(redirect), 32'(e.redirect));
    check("ovf_trap", 32'(ovf_trap), 32'(e.trap));
    if (e.dp) begin
      check("mem_aluresult", mem_aluresult, e.res);
      check("fwd_data", fwd_data, e.res);
      check("mem_storedata", mem_storedata, e.sd);
      check("mem_rd", 32'(mem_rd), 32'(e.rd));
      check("redirect_pc", redirect_pc, e.rpc);
    end
  endtask

  initial begin
    int pulses;
    idle_inputs();
    {m_valid, m_rw, m_mr, m_mw, m_taken, m_done, m_trap, m_dp} = '0;
    m_res = '0; m_sd = '0; m_tgt = '0; m_rd = '0; m_flags = '0;

    // Reset
    reset = 1; step(); step();
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    reset = 0;

    // 1: plain ADD
    idle_inputs();
    ex_valid = 1; alu_out = 32'h0000_18AB; ex_rd = 5'd5; ex_regwrite = 1;
    step();
    check("t1_res", mem_aluresult, 32'h0000_18AB);
    check("t1_fwd_rd", 32'(fwd_rd), 32'd5);

    // 2: overflow trap, then acknowledge
    idle_inputs();
    ex_valid = 1; alu_out = 32'h8000_0000; alu_ovf = 1; alu_neg = 1;
    ex_trap_ovf = 1; ex_regwrite = 1; ex_setflags = 1; ex_rd = 5'd7;
    step();
    check("t2_trap", 32'(ovf_trap), 32'd1);
    check("t2_regwrite", 32'(mem_regwrite), 32'd0);
    check("t2_flags", 32'(flags_q), 32'd0);
    idle_inputs(); trap_ack = 1;
    step();
    check("t2_ack", 32'(ovf_trap), 32'd0);

    // 3: taken BR_EQ held through a 3-cycle stall, then an untaken BR_NE
    idle_inputs();
    ex_valid = 1; ex_branch = 2'b01; alu_zero = 1; ex_target = 32'h0000_0040;
    step();
    pulses = int'(redirect);
    check("t3_rpc", redirect_pc, 32'h0000_0040);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(redirect);
    end
    check("t3_pulses", 32'(pulses), 32'd1);
    idle_inputs();
    ex_valid = 1; ex_branch = 2'b10; alu_zero = 1;
    step();
    check("t3_ne", 32'(redirect), 32'd0);

    // 5: SUB 80000000-1 setting flags; rd=0 never forwards
    idle_inputs();
    ex_valid = 1; alu_out = 32'h7FFF_FFFF; alu_ovf = 1; alu_carry = 1;
    ex_setflags = 1; ex_regwrite = 1; ex_rd = 5'd0;
    step();
    check("t5_flags", 32'(flags_q), 32'h3);
    check("t5_fwd_rd0", 32'(fwd_rd), 32'd0);

    // 4: flush and stall together with a valid store
    idle_inputs();
    flush = 1; stall = 1; ex_valid = 1; ex_memwrite = 1; ex_setflags = 1;
    alu_neg = 1; alu_zero = 1; alu_ovf = 1; alu_carry = 1; ex_storedata = 32'hDEAD_BEEF;
    step();
    check("t4_valid", 32'(mem_valid), 32'd0);
    check("t4_memwrite", 32'(mem_memwrite), 32'd0);
    check("t4_flags", 32'(flags_q), 32'h3);

    // 6: reset during a stall with a pending redirect
    idle_inputs();
    ex_valid = 1; ex_branch = 2'b11; alu_neg = 1; ex_target = 32'h0000_1000; ex_regwrite = 1; ex_rd = 5'd9;
    step();
    check("t6_pending", 32'(redirect), 32'd1);
    idle_inputs();
    stall = 1; reset = 1;
    step();
    check("t6_redirect", 32'(redirect), 32'd0);
    check("t6_rpc", redirect_pc, 32'd0);
    check("t6_fwd", 32'(fwd_rd), 32'd0);
    reset = 0;
    step();
    check("t6_after", 32'(redirect), 32'd0);

    // Random mix of loads, stalls, flushes, traps and acknowledges
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      flush        = ($urandom_range(0, 5) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      trap_ack     = ($urandom_range(0, 3) == 0);
      ex_valid     = ($urandom_range(0, 4) != 0);
      alu_out      = $urandom;
      ex_storedata = $urandom;
      ex_target    = $urandom;
      {alu_carry, alu_zero, alu_ovf, alu_neg} = 4'($urandom);
      ex_rd        = 5'($urandom);
      {ex_regwrite, ex_memread, ex_memwrite, ex_setflags} = 4'($urandom);
      ex_trap_ovf  = ($urandom_range(0, 2) == 0);
      ex_branch    = 2'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
